rs_encode_wrapper: RTL and testbench

Systematic Reed-Solomon encoder over GF(2^8) that produces the 200-byte codewords consumed by the on-chip RS decode path. It takes a K-byte message presented in parallel and feeds it byte-serially through a parity LFSR. It then returns the full N-byte codeword (message followed by parity) on a parallel bus with a ready/valid style status. It sits between the key/ID source logic and the storage or transport that is later checked by the decoder.

---
 rtl/rs_enc_pkg.sv | 49 ++++
 rtl/rs_enc_lfsr.sv | 40 ++++
 rtl/rs_encode_wrapper.sv | 133 +++++++++++++
 tb/tb_rs_encode_wrapper.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_enc_pkg.sv
// Shared definitions for the RS(200,184) encoder: the GF(2^8) field, the
// generator polynomial coefficients and the encoder FSM state type.
package rs_enc_pkg;

    // Field: GF(2^8) with primitive polynomial x^8+x^4+x^3+x^2+1, alpha = 2
    localparam logic [8:0] GF_POLY    = 9'h11D;
    localparam logic [7:0] GF_ALPHA   = 8'h02;
    localparam int         MAX_PARITY = 64;

    // Encoder FSM states; the remaining 3-bit codes fall back to IDLE
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FEED     = 3'd1,
        ST_LATCH    = 3'd2,
        ST_COMPLETE = 3'd3
    } enc_state_t;

    // Shift-and-reduce GF(2^8) multiply; with a constant operand it collapses
    // to a small XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = sh[7] ? ((sh << 1) ^ GF_POLY[7:0]) : (sh << 1);
        end
        return acc;
    endfunction

    // Coefficient g_j of g(x) = prod_{i=0}^{p-1} (x + alpha^i).  Evaluated at
    // elaboration only, so the LFSR taps become constants.
    function automatic logic [7:0] gen_coef(input int p, input int j);
        logic [(MAX_PARITY+1)*8-1:0] g;
        logic [7:0]                  root;
        g         = '0;
        g[7:0]    = 8'h01;
        root      = 8'h01;
        for (int i = 0; i < p; i++) begin
            for (int k = i + 1; k > 0; k--)
                g[k*8 +: 8] = g[(k-1)*8 +: 8] ^ gf_mul(g[k*8 +: 8], root);
            g[7:0] = gf_mul(g[7:0], root);
            root   = gf_mul(root, GF_ALPHA);
        end
        return g[j*8 +: 8];
    endfunction

endpackage

// File: rtl/rs_enc_lfsr.sv
// Parity LFSR for the systematic RS encoder: divides the message polynomial
// (first byte = highest degree) by g(x), one byte per shift.
module rs_lfsr_enc
    import rs_enc_pkg::*;
#(
    parameter int NPARITY = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 shift,
    input  logic [7:0]           din,
    output logic [NPARITY*8-1:0] parity
);

    // r[j] lives in bits [j*8 +: 8]; r[NPARITY-1] is the highest-degree term
    logic [NPARITY*8-1:0] r;
    logic [NPARITY*8-1:0] prod;
    logic [7:0]           fb;

    assign fb = din ^ r[NPARITY*8-1 -: 8];

    for (genvar j = 0; j < NPARITY; j++) begin : g_tap
        localparam logic [7:0] GJ = gen_coef(NPARITY, j);
        assign prod[j*8 +: 8] = gf_mul(fb, GJ);
    end

    // Clear before a new message, otherwise shift one byte in per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r <= '0;
        else if (clr)
            r <= '0;
        else if (shift)
            r <= {r[NPARITY*8-9:0], 8'h00} ^ prod;
    end

    assign parity = r;

endmodule

// File: rtl/rs_encode_wrapper.sv
// RS(NBYTES, NBYTES-NPARITY) encoder wrapper: accepts a parallel message,
// feeds it byte-serially through the parity LFSR and presents the full
// systematic codeword (message then parity) with sticky valid / ready.
module rs_encode_wrapper
    import rs_enc_pkg::*;
#(
    parameter  int NBYTES  = 200,
    parameter  int NPARITY = 16,
    localparam int KBYTES  = NBYTES - NPARITY
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clrn,
    input  logic                scan_mode,
    input  logic                encode_en,
    input  logic [KBYTES*8-1:0] message,
    output logic [NBYTES*8-1:0] codeword,
    output logic                output_valid,
    output logic                ready
);

    enc_state_t           state;
    enc_state_t           state_nxt;
    logic [7:0]           cnt;
    logic [7:0]           cnt_nxt;
    logic                 ready_nxt;
    logic                 valid_nxt;
    logic                 lfsr_clr;
    logic                 lfsr_shift;
    logic                 cw_load;
    logic                 clr_eff;
    logic [7:0]           msg_byte [KBYTES];
    logic [NPARITY*8-1:0] parity;
    logic [NPARITY*8-1:0] parity_ord;

    // Scan mode masks the functional clear so scan shifting cannot abort a run
    assign clr_eff = !clrn && !scan_mode;

    for (genvar i = 0; i < KBYTES; i++) begin : g_msg
        assign msg_byte[i] = message[i*8 +: 8];
    end

    // Highest-degree remainder term goes out first, right after the message
    for (genvar j = 0; j < NPARITY; j++) begin : g_par
        assign parity_ord[j*8 +: 8] = parity[(NPARITY-1-j)*8 +: 8];
    end

    rs_lfsr_enc #(
        .NPARITY (NPARITY)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (lfsr_clr),
        .shift  (lfsr_shift),
        .din    (msg_byte[cnt]),
        .parity (parity)
    );

    // Next-state, counter and handshake decode; clear overrides everything
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        ready_nxt  = ready;
        valid_nxt  = output_valid;
        lfsr_clr   = 1'b0;
        lfsr_shift = 1'b0;
        cw_load    = 1'b0;
        if (clr_eff) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = 8'd0;
            ready_nxt = 1'b1;
            valid_nxt = 1'b0;
            lfsr_clr  = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (encode_en) begin
                        state_nxt = ST_FEED;
                        cnt_nxt   = 8'd0;
                        ready_nxt = 1'b0;
                        valid_nxt = 1'b0;
                        lfsr_clr  = 1'b1;
                    end
                end
                ST_FEED: begin
                    lfsr_shift = 1'b1;
                    cnt_nxt    = cnt + 8'd1;
                    if (cnt == 8'(KBYTES - 1))
                        state_nxt = ST_LATCH;
                end
                ST_LATCH: begin
                    cw_load   = 1'b1;
                    state_nxt = ST_COMPLETE;
                end
                ST_COMPLETE: begin
                    valid_nxt = 1'b1;
                    ready_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    ready_nxt = 1'b1;
                end
            endcase
        end
    end

    // Control registers: state, byte counter and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= 8'd0;
            ready        <= 1'b1;
            output_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            ready        <= ready_nxt;
            output_valid <= valid_nxt;
        end
    end

    // Codeword register: written once per run, so an aborted run never shows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            codeword <= '0;
        else if (clr_eff)
            codeword <= '0;
        else if (cw_load)
            codeword <= {parity_ord, message};
    end

endmodule

// File: tb/tb_rs_encode_wrapper.sv
// Scoreboard bench for rs_encode_wrapper: directed and random messages,
// expected codewords from a log/exp-table long-division model, plus
// abort, clear, scan-mask and ignored-request scenarios.
module tb_rs_encode_wrapper;

    localparam int NB = 200;
    localparam int NP = 16;
    localparam int KB = NB - NP;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clrn;
    logic             scan_mode;
    logic             encode_en;
    logic [KB*8-1:0]  message;
    logic [NB*8-1:0]  codeword;
    logic             output_valid;
    logic             ready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [NB*8-1:0] cw;
        int              due;
    } exp_t;
    exp_t sb[$];

    logic [7:0] gexp  [0:255];
    int         glog  [0:255];
    logic [7:0] gfull [0:NP];

    rs_encode_wrapper #(
        .NBYTES  (NB),
        .NPARITY (NP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clrn         (clrn),
        .scan_mode    (scan_mode),
        .encode_en    (encode_en),
        .message      (message),
        .codeword     (codeword),
        .output_valid (output_valid),
        .ready        (ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] tmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    task automatic build_tables();
        logic [8:0] x;
        x = 9'h001;
        for (int i = 0; i < 255; i++) begin
            gexp[i]       = x[7:0];
            glog[x[7:0]]  = i;
            x = x << 1;
            if (x[8]) x = x ^ 9'h11D;
        end
        gexp[255] = gexp[0];
        glog[0]   = 0;
        for (int k = 0; k <= NP; k++) gfull[k] = 8'h00;
        gfull[0] = 8'h01;
        for (int i = 0; i < NP; i++) begin
            for (int k = i + 1; k > 0; k--) gfull[k] = gfull[k-1] ^ tmul(gfull[k], gexp[i]);
            gfull[0] = tmul(gfull[0], gexp[i]);
        end
    endtask

    // Textbook long division of m(x)*x^NP by the monic g(x)
    function automatic logic [NB*8-1:0] model_encode(input logic [KB*8-1:0] m);
        logic [7:0]      b [0:NB-1];
        logic [NB*8-1:0] cw;
        logic [7:0]      coef;
        for (int i = 0; i < NB; i++) begin
            if (i < KB) b[i] = m[i*8 +: 8];
            else        b[i] = 8'h00;
        end
        for (int i = 0; i < KB; i++) begin
            coef = b[i];
            for (int j = 1; j <= NP; j++) b[i+j] = b[i+j] ^ tmul(coef, gfull[NP-j]);
        end
        for (int i = 0; i < NB; i++) cw[i*8 +: 8] = (i < KB) ? m[i*8 +: 8] : b[i];
        return cw;
    endfunction

    // Number of roots alpha^0..alpha^(NP-1) at which the codeword is non-zero
    function automatic int syndrome_bad(input logic [NB*8-1:0] cw);
        int         n;
        logic [7:0] acc;
        n = 0;
        for (int s = 0; s < NP; s++) begin
            acc = 8'h00;
            for (int i = 0; i < NB; i++) acc = tmul(acc, gexp[s]) ^ cw[i*8 +: 8];
            if (acc != 8'h00) n++;
        end
        return n;
    endfunction

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic check_cw(input string name, input logic [NB*8-1:0] got, input logic [NB*8-1:0] exp);
        total++;
        if (got !== exp) begin
            int idx;
            idx = 0;
            for (int i = NB - 1; i >= 0; i--) if (got[i*8 +: 8] !== exp[i*8 +: 8]) idx = i;
            bad++;
            $display("FAIL %s: first differing byte %0d got=%02h expected=%02h",
                     name, idx, got[idx*8 +: 8], exp[idx*8 +: 8]);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_val(name, ready, 1);
    endtask

    task automatic start_encode(input logic [KB*8-1:0] m, input logic [NB*8-1:0] exp_cw, input bit track);
        exp_t e;
        wait_ready("ready_before_start");
        message   = m;
        encode_en = 1'b1;
        @(negedge clk);
        encode_en = 1'b0;
        check_val("ready_low_after_accept", ready, 0);
        check_val("valid_low_after_accept", output_valid, 0);
        if (track) begin
            e.cw  = exp_cw;
            e.due = cyc + KB + 2;
            sb.push_back(e);
        end
    endtask

    // Monitor: every rising output_valid must match the oldest pending request
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (output_valid === 1'b1 && prev_valid !== 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got output_valid=1 expected no completion");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_cw("codeword", codeword, e.cw);
                check_val("latency_cycle", cyc, e.due);
                check_val("syndrome_nonzero", syndrome_bad(codeword), 0);
            end
        end
        prev_valid <= output_valid;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [KB*8-1:0] m;
        logic [KB*8-1:0] ma;
        logic [KB*8-1:0] mb;
        logic [NB*8-1:0] x;

        build_tables();
        rst_n     = 1'b0;
        clrn      = 1'b1;
        scan_mode = 1'b0;
        encode_en = 1'b0;
        message   = '0;
        repeat (3) @(negedge clk);
        check_val("reset_ready", ready, 1);
        check_val("reset_valid", output_valid, 0);
        check_cw("reset_codeword", codeword, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // All-zero message gives an all-zero codeword
        start_encode('0, '0, 1'b1);

        // Unit message in the last byte: parity is the generator itself
        m = '0;
        m[(KB-1)*8 +: 8] = 8'h01;
        x = '0;
        x[KB*8-1:0] = m;
        for (int j = 0; j < NP; j++) x[(KB+j)*8 +: 8] = gfull[NP-1-j];
        start_encode(m, x, 1'b1);
        wait_ready("ready_after_unit");
        repeat (5) @(negedge clk);
        check_val("valid_sticky", output_valid, 1);
        check_cw("codeword_hold", codeword, x);

        // Directed patterns
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < KB; i++) begin
                case (p)
                    0:       m[i*8 +: 8] = 8'hFF;
                    1:       m[i*8 +: 8] = 8'(i);
                    2:       m[i*8 +: 8] = (i % 2 == 1) ? 8'h5A : 8'hA5;
                    default: m[i*8 +: 8] = (i == 0) ? 8'h80 : 8'h00;
                endcase
            end
            start_encode(m, model_encode(m), 1'b1);
        end

        // Linearity: codeword(a^b) = codeword(a) ^ codeword(b)
        for (int i = 0; i < KB; i++) begin
            ma[i*8 +: 8] = 8'(i * 7 + 3);
            mb[i*8 +: 8] = 8'(255 - i);
        end
        x = model_encode(ma) ^ model_encode(mb);
        start_encode(ma ^ mb, x, 1'b1);

        // Random messages, issued back to back
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < KB; i++) m[i*8 +: 8] = 8'($urandom_range(0, 255));
            start_encode(m, model_encode(m), 1'b1);
        end

        // Asynchronous reset in the middle of FEED
        for (int i = 0; i < KB; i++) m[i*8 +: 8] = 8'(i + 1);
        start_encode(m, '0, 1'b0);
        repeat (89) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("abort_rst_ready", ready, 1);
        check_val("abort_rst_valid", output_valid, 0);
        check_cw("abort_rst_codeword", codeword, '0);
        @(negedge clk);
        rst_n = 1'b1;
        start_encode(m, model_encode(m), 1'b1);

        // Synchronous clear in the middle of FEED
        for (int i = 0; i < KB; i++) m[i*8 +: 8] = 8'(3 * i + 17);
        start_encode(m, '0, 1'b0);
        repeat (50) @(negedge clk);
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        check_val("abort_clr_ready", ready, 1);
        check_val("abort_clr_valid", output_valid, 0);
        check_cw("abort_clr_codeword", codeword, '0);

        // Clear and request together: the request is dropped
        clrn      = 1'b0;
        encode_en = 1'b1;
        @(negedge clk);
        clrn      = 1'b0 | 1'b1;
        encode_en = 1'b0;
        check_val("clear_wins_ready", ready, 1);
        @(negedge clk);
        check_val("no_queued_request", ready, 1);
        check_val("no_queued_valid", output_valid, 0);

        // Stray encode_en during FEED and a scan-masked clear leave the run intact
        for (int i = 0; i < KB; i++) m[i*8 +: 8] = 8'(i * i + 5);
        start_encode(m, model_encode(m), 1'b1);
        repeat (20) @(negedge clk);
        encode_en = 1'b1;
        @(negedge clk);
        encode_en = 1'b0;
        repeat (20) @(negedge clk);
        scan_mode = 1'b1;
        clrn      = 1'b0;
        repeat (3) @(negedge clk);
        clrn      = 1'b1;
        scan_mode = 1'b0;

        wait_ready("ready_at_end");
        repeat (3) @(negedge clk);
        check_val("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
